muldiv_unit: RTL

- Iterative, multi-cycle RV64M multiply/divide unit for the execute stage.
- Issue side: valid/ready handshake. Result side: valid/ready handshake.
- Takes MUL/DIV/REM ops off the combinational ALU path. Honours full RISC-V semantics: upper product halves, divide-by-zero, signed overflow, W-variant sign-extension.
- Parametrised in XLEN and tag width; one operation in flight.

---
 rtl/muldiv_pkg.sv | 60 ++++++
 rtl/muldiv_core.sv | 88 ++++++++
 rtl/muldiv_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Op codes, FSM state encoding and op-class decode helpers for the multiply/divide unit.
// Latency: not applicable (definitions only).
// Backpressure: not applicable.
package muldiv_pkg;

    localparam logic [7:0] OP_MUL    = 8'd10;
    localparam logic [7:0] OP_MULH   = 8'd11;
    localparam logic [7:0] OP_MULHSU = 8'd12;
    localparam logic [7:0] OP_MULHU  = 8'd13;
    localparam logic [7:0] OP_DIV    = 8'd14;
    localparam logic [7:0] OP_DIVU   = 8'd15;
    localparam logic [7:0] OP_REM    = 8'd16;
    localparam logic [7:0] OP_REMU   = 8'd17;
    localparam logic [7:0] OP_MULW   = 8'd38;
    localparam logic [7:0] OP_DIVW   = 8'd39;
    localparam logic [7:0] OP_DIVUW  = 8'd40;
    localparam logic [7:0] OP_REMW   = 8'd41;
    localparam logic [7:0] OP_REMUW  = 8'd42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_base_op(input logic [7:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_word_op(input logic [7:0] op);
        return (op >= OP_MULW) && (op <= OP_REMUW);
    endfunction

    function automatic logic is_div(input logic [7:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem(input logic [7:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_high(input logic [7:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // MUL/MULW low halves are sign-agnostic; treating them as signed is harmless.
    function automatic logic is_signed_a(input logic [7:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                          OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_signed_b(input logic [7:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM,
                          OP_MULW, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: MSB-first shift-add multiply or restoring divide, one bit per cycle.
// Latency: N cycles after start (N = 32 for word ops, else XLEN); done is high during the last iteration.
// Backpressure: none; kill aborts a running operation, results hold until the next start.
module muldiv_core #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              kill,
    input  logic              div_mode,
    input  logic              word,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0]   a_sh;
    logic [XLEN-1:0]   b_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;
    logic              div_r;

    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic              ge;

    // Restoring-divide trial subtraction for the current dividend bit.
    always_comb begin
        trial = {rem, a_sh[XLEN-1]};
        diff  = trial - {1'b0, b_r};
        ge    = (trial >= {1'b0, b_r});
    end

    assign done      = busy && (cnt == CW'(1));
    assign product   = acc;
    assign quotient  = quo;
    assign remainder = rem;

    // Load operands on start, then consume one operand bit per cycle, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_r   <= '0;
            acc   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
            busy  <= 1'b0;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            // Word operands are left-aligned so the MSB tap is the same for both widths.
            a_sh  <= word ? (a << (XLEN - 32)) : a;
            b_r   <= b;
            acc   <= '0;
            quo   <= '0;
            rem   <= '0;
            div_r <= div_mode;
            cnt   <= word ? CW'(32) : CW'(XLEN);
            busy  <= 1'b1;
        end else if (busy) begin
            a_sh <= a_sh << 1;
            if (div_r) begin
                rem <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
                quo <= {quo[XLEN-2:0], ge};
            end else begin
                acc <= {acc[2*XLEN-2:0], 1'b0} +
                       (a_sh[XLEN-1] ? {{XLEN{1'b0}}, b_r} : {(2*XLEN){1'b0}});
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV64M multiply/divide unit: IDLE -> PREP -> CALC (N cycles) -> FIX -> DONE; MULDIV_EARLY_OUT_EN lets trivial ops skip CALC.
// Latency: out_valid N+2 cycles after accept (N = 32 for W ops, else XLEN); illegal op codes take 1 cycle.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready; flush kills at any point.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    state_t           state;
    logic [7:0]       op_r;
    logic [XLEN-1:0]  rs1_r;
    logic [XLEN-1:0]  rs2_r;
    logic [TAG_W-1:0] tag_r;
    logic             neg_prod_r;
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic             dz_r;
    logic             ov_r;
`ifdef MULDIV_EARLY_OUT_EN
    logic             early_zero_r;
    logic             early_small_r;
`endif

    // Operand decode derived from the latched op
    logic             word;
    logic             op_div;
    logic             legal;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  b_ext;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             overflow;
    logic             skip;

    // Result assembly
    logic [2*XLEN-1:0] prod_v;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_v;
    logic [XLEN-1:0]   rem_v;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   fix_result;

    logic              core_start;
    logic              core_busy;
    logic              core_done;
    logic [2*XLEN-1:0] core_product;
    logic [XLEN-1:0]   core_quotient;
    logic [XLEN-1:0]   core_remainder;

    // Extend operands to XLEN per op signedness, derive magnitudes and the special divide cases.
    always_comb begin
        word   = is_word_op(op_r);
        op_div = is_div(op_r);
        legal  = is_base_op(op_r) || ((XLEN == 64) && is_word_op(op_r));
        if (word) begin
            a_ext = is_signed_a(op_r) ? XLEN'($signed(rs1_r[31:0])) : XLEN'(rs1_r[31:0]);
            b_ext = is_signed_b(op_r) ? XLEN'($signed(rs2_r[31:0])) : XLEN'(rs2_r[31:0]);
        end else begin
            a_ext = rs1_r;
            b_ext = rs2_r;
        end
        a_neg    = is_signed_a(op_r) && a_ext[XLEN-1];
        b_neg    = is_signed_b(op_r) && b_ext[XLEN-1];
        a_mag    = a_neg ? (~a_ext + XLEN'(1)) : a_ext;
        b_mag    = b_neg ? (~b_ext + XLEN'(1)) : b_ext;
        div_zero = op_div && (b_ext == '0);
        overflow = op_div && is_signed_a(op_r) && (b_ext == '1) &&
                   (word ? (a_ext[31:0] == 32'h8000_0000)
                         : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
`ifdef MULDIV_EARLY_OUT_EN
        skip = op_div ? (div_zero || overflow || (a_mag < b_mag))
                      : ((a_ext == '0) || (b_ext == '0));
`else
        skip = 1'b0;
`endif
    end

    assign core_start = (state == S_PREP) && legal && !skip && !flush;

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .kill      (flush),
        .div_mode  (op_div),
        .word      (word),
        .a         (a_mag),
        .b         (b_mag),
        .busy      (core_busy),
        .done      (core_done),
        .product   (core_product),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    // Re-apply signs, pick the result half and patch divide-by-zero / overflow results.
    always_comb begin
        prod_v = core_product;
        quo_v  = core_quotient;
        rem_v  = core_remainder;
`ifdef MULDIV_EARLY_OUT_EN
        if (early_zero_r) begin
            prod_v = '0;
        end
        if (early_small_r) begin
            quo_v = '0;
            rem_v = a_mag;
        end
`endif
        prod_s = neg_prod_r ? (~prod_v + (2*XLEN)'(1)) : prod_v;
        quo_s  = neg_quo_r  ? (~quo_v  + XLEN'(1))     : quo_v;
        rem_s  = neg_rem_r  ? (~rem_v  + XLEN'(1))     : rem_v;
        if (op_div) begin
            if (is_rem(op_r)) begin
                res = dz_r ? a_ext : (ov_r ? '0 : rem_s);
            end else begin
                res = dz_r ? '1 : (ov_r ? a_ext : quo_s);
            end
        end else begin
            res = is_high(op_r) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        fix_result = word ? XLEN'($signed(res[31:0])) : res;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_tag       <= '0;
            out_illegal   <= 1'b0;
            op_r          <= '0;
            rs1_r         <= '0;
            rs2_r         <= '0;
            tag_r         <= '0;
            neg_prod_r    <= 1'b0;
            neg_quo_r     <= 1'b0;
            neg_rem_r     <= 1'b0;
            dz_r          <= 1'b0;
            ov_r          <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            early_zero_r  <= 1'b0;
            early_small_r <= 1'b0;
`endif
        end else if (flush) begin
            // Flush wins over everything, including an accept in the same cycle.
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r     <= in_op;
                        rs1_r    <= in_rs1;
                        rs2_r    <= in_rs2;
                        tag_r    <= in_tag;
                        in_ready <= 1'b0;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (!legal) begin
                        out_result  <= '0;
                        out_illegal <= 1'b1;
                        out_tag     <= tag_r;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        neg_prod_r <= a_neg ^ b_neg;
                        neg_quo_r  <= a_neg ^ b_neg;
                        neg_rem_r  <= a_neg;
                        dz_r       <= div_zero;
                        ov_r       <= overflow;
`ifdef MULDIV_EARLY_OUT_EN
                        early_zero_r  <= !op_div && skip;
                        early_small_r <= op_div && !div_zero && !overflow && skip;
`endif
                        state <= skip ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    // The idle-core term only guards against a stuck CALC.
                    if (core_done || !core_busy) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    out_result  <= fix_result;
                    out_illegal <= 1'b0;
                    out_tag     <= tag_r;
                    out_valid   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
